// File: rtl/hdmi_pkg.sv
// Shared period codes, control-symbol constants and helpers for the TMDS period scheduler.
package hdmi_pkg;

  typedef enum logic [2:0] {
    CTRL  = 3'd0,
    VPRE  = 3'd1,
    VGB   = 3'd2,
    VIDEO = 3'd3,
    DPRE  = 3'd4,
    DGB_L = 3'd5,
    DATA  = 3'd6,
    DGB_T = 3'd7
  } period_e;

  localparam int unsigned PKT_LEN  = 32;
  localparam logic [3:0]  CTL_VPRE = 4'b0001;
  localparam logic [3:0]  CTL_DPRE = 4'b0101;

  function automatic logic [3:0] ctl_code(input period_e p);
    case (p)
      VPRE:    return CTL_VPRE;
      DPRE:    return CTL_DPRE;
      default: return 4'b0000;
    endcase
  endfunction

  // An empty island is still sent as one packet; oversize requests are capped.
  function automatic logic [4:0] clamp_npkt(input logic [4:0] n, input int unsigned max_pkts);
    if (n == 5'd0) return 5'd1;
    if (32'(n) > max_pkts) return 5'(max_pkts);
    return n;
  endfunction

endpackage

// File: rtl/tmds_period_sched_if.sv
// Timing, island handshake and period outputs of the scheduler; master drives, slave schedules.
interface tmds_period_sched_if;
  import hdmi_pkg::*;

  logic       i_de;
  logic       i_hsync;
  logic       i_vsync;
  logic       i_island_req;
  logic [4:0] i_island_npkt;
  logic       i_island_window;

  logic       o_island_ack;
  logic       o_island_abort;
  period_e    o_period;
  logic [3:0] o_ctl;
  logic       o_de;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_pkt_start;
  logic [4:0] o_pkt_idx;
  logic [4:0] o_char_idx;

  modport master (
    output i_de, i_hsync, i_vsync, i_island_req, i_island_npkt, i_island_window,
    input  o_island_ack, o_island_abort, o_period, o_ctl, o_de, o_hsync, o_vsync,
           o_pkt_start, o_pkt_idx, o_char_idx
  );

  modport slave (
    input  i_de, i_hsync, i_vsync, i_island_req, i_island_npkt, i_island_window,
    output o_island_ack, o_island_abort, o_period, o_ctl, o_de, o_hsync, o_vsync,
           o_pkt_start, o_pkt_idx, o_char_idx
  );
endinterface

// File: rtl/tmds_delay_line.sv
// WIDTH x DEPTH shift register with synchronous clear, used to look ahead of the timing stream.
module tmds_delay_line #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/tmds_period_sched.sv
// Per-character HDMI period scheduler: inserts preambles/guard bands ahead of delayed video
// and grants data-island slots during control periods.
module tmds_period_sched
  import hdmi_pkg::*;
#(
  parameter int unsigned PRE_LEN  = 8,
  parameter int unsigned GB_LEN   = 2,
  parameter int unsigned MIN_CTL  = 12,
  parameter int unsigned MAX_PKTS = 18
) (
  input logic                i_pclk,
  input logic                i_rst,
  tmds_period_sched_if.slave bus
);

  localparam int unsigned LOOK = PRE_LEN + GB_LEN;
  localparam int unsigned CW   = $clog2(LOOK + 1);
  localparam int unsigned KW   = $clog2(MIN_CTL + 1);

  period_e       state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [KW-1:0] ctl_cnt;
  logic [4:0]    char_idx, pkt_idx, char_nxt, pkt_nxt, npkt;
  logic          de_prev, de_rise, grant, abort_nxt, last_char, last_pkt;
  logic          ack_q, abort_q;
  logic [2:0]    tap, out_q;

  tmds_delay_line #(
    .WIDTH(3),
    .DEPTH(LOOK)
  ) u_delay (
    .clk (i_pclk),
    .clr (i_rst),
    .d   ({bus.i_vsync, bus.i_hsync, bus.i_de}),
    .q   (tap)
  );

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    abort_nxt = 1'b0;
    de_rise   = bus.i_de & ~de_prev;
    last_char = (char_idx == 5'(PKT_LEN - 1));
    last_pkt  = (pkt_idx == npkt - 5'd1);

    case (state)
      CTRL: begin
        if (de_rise) begin
          state_nxt = VPRE;
        end else if (ctl_cnt == KW'(MIN_CTL) && bus.i_island_req && bus.i_island_window) begin
          grant     = 1'b1;
          state_nxt = DPRE;
        end
      end
      VPRE:    if (cnt == CW'(PRE_LEN - 1)) state_nxt = VGB;
      VGB:     if (cnt == CW'(GB_LEN - 1))  state_nxt = VIDEO;
      // tap[0] is the DE that becomes o_de next cycle, so period and o_de drop together
      VIDEO:   if (!tap[0]) state_nxt = CTRL;
      DPRE:    if (cnt == CW'(PRE_LEN - 1)) state_nxt = DGB_L;
      DGB_L:   if (cnt == CW'(GB_LEN - 1))  state_nxt = DATA;
      DATA:    if (last_char && last_pkt)   state_nxt = DGB_T;
      DGB_T:   if (cnt == CW'(GB_LEN - 1))  state_nxt = CTRL;
      default: state_nxt = CTRL;
    endcase

    // Video that arrives inside an island wins; the island is cut and the video preamble starts.
    if (de_rise && (state inside {DPRE, DGB_L, DATA, DGB_T})) begin
      abort_nxt = 1'b1;
      state_nxt = VPRE;
    end

    cnt_nxt  = (state_nxt != state) ? '0 : cnt + CW'(1);
    char_nxt = '0;
    pkt_nxt  = '0;
    if (state == DATA && state_nxt == DATA) begin
      char_nxt = last_char ? '0 : char_idx + 5'd1;
      pkt_nxt  = last_char ? pkt_idx + 5'd1 : pkt_idx;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      state    <= CTRL;
      cnt      <= '0;
      ctl_cnt  <= '0;
      char_idx <= '0;
      pkt_idx  <= '0;
      npkt     <= '0;
      de_prev  <= 1'b0;
      ack_q    <= 1'b0;
      abort_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      char_idx <= char_nxt;
      pkt_idx  <= pkt_nxt;
      de_prev  <= bus.i_de;
      ack_q    <= grant;
      abort_q  <= abort_nxt;
      out_q    <= tap;
      if (state != CTRL) begin
        ctl_cnt <= '0;
      end else if (ctl_cnt != KW'(MIN_CTL)) begin
        ctl_cnt <= ctl_cnt + KW'(1);
      end
      if (grant) npkt <= clamp_npkt(bus.i_island_npkt, MAX_PKTS);
    end
  end

  assign bus.o_period      = state;
  assign bus.o_ctl         = ctl_code(state);
  assign bus.o_island_ack  = ack_q;
  assign bus.o_island_abort = abort_q;
  assign bus.o_de          = out_q[0];
  assign bus.o_hsync       = out_q[1];
  assign bus.o_vsync       = out_q[2];
  assign bus.o_pkt_start   = (state == DATA) && (char_idx == 5'd0);
  assign bus.o_pkt_idx     = pkt_idx;
  assign bus.o_char_idx    = char_idx;

endmodule

// File: tb/tb_tmds_period_sched.sv
// Self-checking bench for tmds_period_sched: randomized timing/requests against an
// event-time reference model of the HDMI period schedule.
module tb_tmds_period_sched;

  localparam int PRE  = 8;
  localparam int GB   = 2;
  localparam int MINC = 12;
  localparam int MAXP = 18;
  localparam int LOOK = PRE + GB;

  localparam logic [2:0] P_CTRL = 3'd0, P_VPRE = 3'd1, P_VGB = 3'd2, P_VIDEO = 3'd3;
  localparam logic [2:0] P_DPRE = 3'd4, P_DGBL = 3'd5, P_DATA = 3'd6, P_DGBT = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  tmds_period_sched_if bus();

  tmds_period_sched #(
    .PRE_LEN (PRE),
    .GB_LEN  (GB),
    .MIN_CTL (MINC),
    .MAX_PKTS(MAXP)
  ) dut (
    .i_pclk(clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: absolute event times rather than per-state counters.
  int          cyc = 0;        // index of the cycle currently on the outputs
  int          mode = 0;       // 0 control, 1 video run (rise at t0), 2 island (grant at t0)
  int          t0 = 0;
  int          ctl_start = 0;  // first cycle of the current control period
  int          n_isl = 1;
  logic        prev_de = 1'b0;
  logic        drop_pending = 1'b0;
  logic [2:0]  dq[$];
  logic [22:0] exp_vec = '0;

  function automatic logic [22:0] dut_vec();
    return {3'(bus.o_period), bus.o_ctl, bus.o_de, bus.o_hsync, bus.o_vsync,
            bus.o_island_ack, bus.o_island_abort, bus.o_pkt_start, bus.o_pkt_idx, bus.o_char_idx};
  endfunction

  // Predict the next cycle from this cycle's inputs, advance one clock, then update sync/req.
  task automatic step();
    logic       rise;
    logic [2:0] ed, per;
    logic [3:0] ctl;
    logic       e_ack, e_abort, ps;
    logic [4:0] pi, ci;
    int         c, d;
    c = cyc;
    e_ack = 1'b0; e_abort = 1'b0; ps = 1'b0; pi = '0; ci = '0; ed = '0;
    if (rst) begin
      mode = 0; ctl_start = c + 1; prev_de = 1'b0;
      dq.delete();
      for (int i = 0; i < LOOK; i++) dq.push_back(3'b000);
    end else begin
      rise = bus.i_de && !prev_de;
      prev_de = bus.i_de;
      dq.push_back({bus.i_vsync, bus.i_hsync, bus.i_de});
      ed = dq.pop_front();
      if (mode == 0) begin
        if (rise) begin
          mode = 1; t0 = c;
        end else if (c - ctl_start >= MINC && bus.i_island_req && bus.i_island_window) begin
          mode = 2; t0 = c; e_ack = 1'b1;
          n_isl = (bus.i_island_npkt == 0) ? 1 :
                  ((int'(bus.i_island_npkt) > MAXP) ? MAXP : int'(bus.i_island_npkt));
        end
      end else if (mode == 2 && rise) begin
        mode = 1; t0 = c; e_abort = 1'b1;
      end
    end
    d = c + 1 - t0;
    per = P_CTRL;
    if (mode == 1) begin
      if (d <= PRE) per = P_VPRE;
      else if (d <= LOOK) per = P_VGB;
      else if (ed[0]) per = P_VIDEO;
      else begin mode = 0; ctl_start = c + 1; end
    end else if (mode == 2) begin
      if (d <= PRE) per = P_DPRE;
      else if (d <= LOOK) per = P_DGBL;
      else if (d <= LOOK + 32 * n_isl) begin
        per = P_DATA;
        ci = 5'((d - LOOK - 1) % 32);
        pi = 5'((d - LOOK - 1) / 32);
        ps = (ci == 5'd0);
      end
      else if (d <= LOOK + 32 * n_isl + GB) per = P_DGBT;
      else begin mode = 0; ctl_start = c + 1; end
    end
    ctl = (per == P_VPRE) ? 4'b0001 : ((per == P_DPRE) ? 4'b0101 : 4'b0000);
    exp_vec = {per, ctl, ed[0], ed[1], ed[2], e_ack, e_abort, ps, pi, ci};

    @(posedge clk);
    cyc++;
    #1;
    bus.i_hsync = 1'($urandom);
    bus.i_vsync = 1'($urandom);
    if (drop_pending) begin bus.i_island_req = 1'b0; drop_pending = 1'b0; end
    if (e_ack) drop_pending = 1'b1;
  endtask

  task automatic test_reset();
    logic [22:0] v;
    int acks = 0;
    rst = 1'b1;
    bus.i_de = 1'($urandom); bus.i_island_req = 1'b1; bus.i_island_window = 1'b1;
    repeat (3) begin
      step(); v = dut_vec(); checks++;
      if (v !== exp_vec) begin errors++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, v, exp_vec); end
      checks++;
      if (v !== 23'd0) begin errors++; $display("FAIL reset_zero cyc=%0d got=%h exp=0", cyc, v); end
    end
    rst = 1'b0; bus.i_de = 1'b0; bus.i_island_req = 1'b0;
    repeat (20) begin
      step(); v = dut_vec(); checks++;
      if (v !== exp_vec) begin errors++; $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, v, exp_vec); end
      if (bus.o_island_ack) acks++;
    end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL idle_ack got=%0d exp=0", acks); end
  endtask

  task automatic test_video(input int len);
    logic [22:0] v;
    int vid = 0, pre = 0, gb = 0, pre1 = 0;
    while (cyc < 30) step();
    bus.i_de = 1'b1;
    for (int k = 0; k < len + 30; k++) begin
      step(); v = dut_vec(); checks++;
      if (v !== exp_vec) begin errors++; $display("FAIL video cyc=%0d got=%h exp=%h", cyc, v, exp_vec); end
      if (k == len - 1) bus.i_de = 1'b0;
      if (v[22:20] == P_VIDEO && v[15]) vid++;
      if (v[22:20] == P_VPRE) pre++;
      if (v[22:20] == P_VPRE && v[19:16] == 4'b0001) pre1++;
      if (v[22:20] == P_VGB) gb++;
    end
    checks++;
    if (vid !== len) begin errors++; $display("FAIL video_len got=%0d exp=%0d", vid, len); end
    checks++;
    if (pre !== PRE || pre1 !== PRE) begin errors++; $display("FAIL video_pre got=%0d/%0d exp=%0d", pre, pre1, PRE); end
    checks++;
    if (gb !== GB) begin errors++; $display("FAIL video_gb got=%0d exp=%0d", gb, GB); end
  endtask

  task automatic test_island(input logic [4:0] npkt);
    logic [22:0] v;
    int n_exp, k, data_cyc = 0, acks = 0, starts = 0;
    logic seen = 1'b0;
    n_exp = (npkt == 0) ? 1 : ((int'(npkt) > MAXP) ? MAXP : int'(npkt));
    bus.i_de = 1'b0; bus.i_island_window = 1'b1; bus.i_island_npkt = npkt; bus.i_island_req = 1'b1;
    for (k = 0; k < 1000; k++) begin
      step(); v = dut_vec(); checks++;
      if (v !== exp_vec) begin errors++; $display("FAIL island cyc=%0d got=%h exp=%h", cyc, v, exp_vec); end
      if (v[22:20] == P_DATA) data_cyc++;
      if (v[12]) acks++;
      if (v[10]) starts++;
      if (mode == 2) seen = 1'b1;
      if (seen && mode == 0) break;
    end
    checks++;
    if (k >= 1000) begin errors++; $display("FAIL island_timeout n=%0d got=%0d exp<1000", npkt, k); end
    checks++;
    if (data_cyc !== 32 * n_exp) begin errors++; $display("FAIL island_data_len n=%0d got=%0d exp=%0d", npkt, data_cyc, 32 * n_exp); end
    checks++;
    if (acks !== 1 || starts !== n_exp) begin
      errors++; $display("FAIL island_ack_start n=%0d got=%0d/%0d exp=1/%0d", npkt, acks, starts, n_exp);
    end
  endtask

  task automatic test_min_ctl();
    logic [22:0] v;
    int k, enter = -1, ack_at = -1;
    bus.i_island_req = 1'b0; bus.i_de = 1'b1;
    step(); bus.i_de = 1'b0;
    for (k = 0; k < 60 && enter < 0; k++) begin
      step(); v = dut_vec(); checks++;
      if (v !== exp_vec) begin errors++; $display("FAIL minctl cyc=%0d got=%h exp=%h", cyc, v, exp_vec); end
      if (mode == 0) enter = cyc;
    end
    repeat (5) step();
    bus.i_island_req = 1'b1; bus.i_island_npkt = 5'd1; bus.i_island_window = 1'b1;
    for (k = 0; k < 40 && ack_at < 0; k++) begin
      step(); v = dut_vec(); checks++;
      if (v !== exp_vec) begin errors++; $display("FAIL minctl_wait cyc=%0d got=%h exp=%h", cyc, v, exp_vec); end
      if (v[12]) ack_at = cyc;
    end
    checks++;
    if (ack_at !== enter + MINC + 1) begin errors++; $display("FAIL minctl_ack got=%0d exp=%0d", ack_at, enter + MINC + 1); end
    for (k = 0; k < 100 && mode != 0; k++) step();
  endtask

  task automatic test_window_low();
    logic [22:0] v;
    int acks = 0;
    bus.i_island_window = 1'b0; bus.i_island_req = 1'b1; bus.i_island_npkt = 5'd3;
    repeat (60) begin
      step(); v = dut_vec(); checks++;
      if (v !== exp_vec) begin errors++; $display("FAIL window_low cyc=%0d got=%h exp=%h", cyc, v, exp_vec); end
      if (v[12]) acks++;
    end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL window_low_ack got=%0d exp=0", acks); end
    bus.i_island_req = 1'b0; bus.i_island_window = 1'b1;
  endtask

  task automatic test_abort();
    logic [22:0] v;
    int k, target, in_data = 0, aborts = 0, pre = 0;
    logic after = 1'b0;
    target = $urandom_range(1, 90);
    bus.i_de = 1'b0; bus.i_island_window = 1'b1; bus.i_island_npkt = 5'd3; bus.i_island_req = 1'b1;
    for (k = 0; k < 300 && in_data < target; k++) begin
      step(); v = dut_vec(); checks++;
      if (v !== exp_vec) begin errors++; $display("FAIL abort_pre cyc=%0d got=%h exp=%h", cyc, v, exp_vec); end
      if (v[22:20] == P_DATA) in_data++;
    end
    bus.i_de = 1'b1;
    for (k = 0; k < 30; k++) begin
      step(); v = dut_vec(); checks++;
      if (v !== exp_vec) begin errors++; $display("FAIL abort cyc=%0d got=%h exp=%h", cyc, v, exp_vec); end
      if (v[11]) begin
        aborts++; after = 1'b1; checks++;
        if (v[22:20] !== P_VPRE) begin errors++; $display("FAIL abort_vpre got=%0d exp=%0d", v[22:20], P_VPRE); end
      end
      if (after && v[22:20] == P_VPRE) pre++;
    end
    bus.i_de = 1'b0;
    for (k = 0; k < 80 && mode != 0; k++) begin
      step(); v = dut_vec(); checks++;
      if (v !== exp_vec) begin errors++; $display("FAIL abort_tail cyc=%0d got=%h exp=%h", cyc, v, exp_vec); end
    end
    checks++;
    if (aborts !== 1 || pre !== PRE) begin errors++; $display("FAIL abort_count got=%0d/%0d exp=1/%0d", aborts, pre, PRE); end
  endtask

  task automatic test_reset_mid();
    logic [22:0] v;
    int k, in_data = 0;
    bus.i_de = 1'b0; bus.i_island_window = 1'b1; bus.i_island_npkt = 5'd4; bus.i_island_req = 1'b1;
    for (k = 0; k < 300 && in_data < 40; k++) begin
      step(); v = dut_vec();
      if (v[22:20] == P_DATA) in_data++;
    end
    rst = 1'b1;
    step(); v = dut_vec(); checks++;
    if (v !== 23'd0) begin errors++; $display("FAIL reset_mid got=%h exp=0", v); end
    rst = 1'b0;
    repeat (20) begin
      step(); v = dut_vec(); checks++;
      if (v !== exp_vec) begin errors++; $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", cyc, v, exp_vec); end
    end
  endtask

  task automatic test_random();
    logic [22:0] v;
    int de_left = 40;
    for (int k = 0; k < 2500; k++) begin
      if (de_left == 0) begin
        bus.i_de = ~bus.i_de;
        de_left = bus.i_de ? $urandom_range(8, 40) : $urandom_range(10, 120);
      end
      de_left--;
      if ($urandom_range(0, 15) == 0) bus.i_island_window = ~bus.i_island_window;
      if (!bus.i_island_req && !drop_pending && $urandom_range(0, 7) == 0) begin
        bus.i_island_req = 1'b1;
        bus.i_island_npkt = 5'($urandom_range(0, 31));
      end
      step(); v = dut_vec(); checks++;
      if (v !== exp_vec) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, v, exp_vec); end
    end
  endtask

  initial begin
    bus.i_de = 1'b0; bus.i_hsync = 1'b0; bus.i_vsync = 1'b0;
    bus.i_island_req = 1'b0; bus.i_island_npkt = '0; bus.i_island_window = 1'b0;
    for (int i = 0; i < LOOK; i++) dq.push_back(3'b000);
    test_reset();
    test_video(16);
    test_island(5'd2);
    test_island(5'd0);
    test_island(5'd25);
    test_min_ctl();
    test_window_low();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_period_sched.md
# tmds_period_sched

Per-pixel-clock scheduler that decides which HDMI period each TMDS character belongs to: control, video preamble, video guard band, active video, data-island preamble, leading guard band, data island, or trailing guard band. It sits between the video timing generator / packet source and the three 10-bit channel encoders feeding the serializing PHY. It delays the video timing stream so that preambles and guard bands can be inserted ahead of active video. It also grants data-island slots to the packet source during blanking.

## Interface
Parameters:
- PRE_LEN, 8, preamble length in characters (video and island)
- GB_LEN, 2, guard-band length in characters
- MIN_CTL, 12, minimum control-period characters before an island may be granted
- MAX_PKTS, 18, maximum packets per data island

Ports. Clock is `i_pclk`; reset is `i_rst`, synchronous and active-high.
- i_pclk  in  1  pixel clock
- i_rst  in  1  synchronous active-high reset
- i_de  in  1  data enable from timing generator (undelayed)
- i_hsync  in  1  hsync (undelayed)
- i_vsync  in  1  vsync (undelayed)
- i_island_req  in  1  packet source requests an island; level, held until ack
- i_island_npkt  in  5  packets in requested island
- i_island_window  in  1  timing generator: a max-length island fits before next DE
- o_island_ack  out  1  one-cycle grant pulse
- o_island_abort  out  1  one-cycle pulse: island cut short by DE
- o_period  out  3  period code (package enum)
- o_ctl  out  4  CTL3..CTL0 for channels 1/2
- o_de, o_hsync, o_vsync  out  1 each  delayed timing, aligned with o_period
- o_pkt_start  out  1  first character of each 32-char packet
- o_pkt_idx  out  5  packet index within island
- o_char_idx  out  5  character index within packet, 0..31

## Operation
- Delay line, depth LOOK = PRE_LEN+GB_LEN. Output register adds 1 cycle, so o_de/o_hsync/o_vsync equal the inputs from LOOK+1 = 11 cycles earlier.
- FSM states: CTRL, VPRE, VGB, VIDEO, DPRE, DGB_L, DATA, DGB_T. o_period is the registered state code.
- CTRL -> VPRE when a rising edge of undelayed i_de is sampled (i_de=1, previous 0).
- VPRE lasts PRE_LEN cycles, then VGB lasts GB_LEN cycles, then VIDEO.
- VIDEO -> CTRL on the cycle the delayed DE is low.
- Island grant fires in CTRL when all of the following hold: ctl_cnt ≥ MIN_CTL, i_island_req=1, i_island_window=1, and no i_de rise is sampled.
  - On grant: pulse o_island_ack and latch N. N = i_island_npkt, with 0 → 1 and >MAX_PKTS → MAX_PKTS.
  - Sequence: DPRE (PRE_LEN) → DGB_L (GB_LEN) → DATA (32·N) → DGB_T (GB_LEN) → CTRL.
- DE rise sampled in DPRE/DGB_L/DATA/DGB_T (protocol violation):
  - pulse o_island_abort and go directly to VPRE; VPRE/VGB timing is unchanged.
  - DE rise takes priority over grant in the same cycle.
- ctl_cnt counts cycles in CTRL, saturates at MIN_CTL, and clears on entry to CTRL.
- o_ctl encoding: 4'b0001 in VPRE, 4'b0101 in DPRE, 4'b0000 otherwise.
- In DATA:
  - o_char_idx counts 0..31 and wraps; o_pkt_idx increments at each wrap.
  - o_pkt_start = 1 when o_char_idx = 0.
  - All three are 0 outside DATA.

## Timing
- Reset: state CTRL, ctl_cnt 0, delay line cleared, all outputs 0 (o_period = CTRL = 0).
- Reset mid-island: next edge returns to CTRL; no ack or abort is generated.
- i_de first high in cycle t produces:
  - o_period = VPRE in t+1..t+8
  - o_period = VGB in t+9..t+10
  - o_period = VIDEO and o_de = 1 from t+11
- Grant sampled in cycle g produces:
  - o_island_ack in cycle g+1
  - DPRE in g+1..g+8, DGB_L in g+9..g+10
  - DATA in g+11..g+10+32N, DGB_T in the next 2 cycles
  - CTRL afterwards
- o_island_ack is registered. The requester drops i_island_req on the cycle after ack. A request still high in CTRL with ctl_cnt < MIN_CTL is not granted.

## Structure
- Package `hdmi_pkg` holds:
  - the period enum: CTRL=0, VPRE=1, VGB=2, VIDEO=3, DPRE=4, DGB_L=5, DATA=6, DGB_T=7
  - PKT_LEN = 32
  - CTL_VPRE and CTL_DPRE constants
- Sub-module `tmds_delay_line`: parameterized WIDTH×DEPTH shift register with synchronous clear, instantiated with WIDTH = 3 (de, hsync, vsync).

## Test plan
- Reset, then idle 20 cycles with i_de=0 → o_period=0, o_ctl=0, no ack.
- Single DE pulse, 16 cycles at t=30:
  - o_period = VPRE in 31..38, VGB in 39..40, VIDEO in 41..56
  - o_de high in 41..56
  - o_ctl = 0001 in 31..38
- Request N=2 after ≥12 CTRL cycles with window high:
  - ack one cycle after grant sample; DPRE 8, DGB_L 2, DATA 64 cycles
  - o_pkt_start at DATA cycles 0 and 32; o_pkt_idx 0 then 1
  - DGB_T 2, then CTRL
- N=0 → 1 packet (32 DATA cycles); N=25 → 18 packets (576 DATA cycles).
- Request pending with ctl_cnt = 5 → no ack until ctl_cnt reaches 12; request with window low → never acked.
- i_de rise during DATA → o_island_abort pulse and VPRE next cycle with standard 8+2 timing; i_rst asserted mid-DATA → all outputs 0 next cycle.
